uart_tx_piso: RTL and testbench

UART_TX_PISO -- requirements
Module: uart_tx_piso

---
 rtl/uart_tx_piso.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_piso.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_piso.sv
// Parallel-in, serial-out UART transmitter: start bit, DATA_BITS data bits (LSB first),
// optional parity bit and one or two stop bits, paced by an external baud_tick strobe.
module uart_tx_piso #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_TYP = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 baud_tick,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 data_tx,
  output logic                 active_flag,
  output logic                 done_flag
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PEND   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  localparam logic       PAR_ON    = (PARITY_EN != 0);
  localparam logic       PAR_ODD   = (PARITY_TYP != 0);
  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  // Stop-counter value during the final stop bit (0 for one stop bit, 1 for two).
  localparam logic       STOP_LAST = (STOP_BITS == 2);

  state_t               state_reg, state_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [3:0]           bit_cnt_reg, bit_cnt_next;
  logic                 stop_cnt_reg, stop_cnt_next;
  logic                 parity_reg, parity_next;
  logic                 data_tx_reg, data_tx_next;
  logic                 active_reg, active_next;
  logic                 done_reg, done_next;

  logic [DATA_BITS:0]   par_chain;
  logic                 par_calc;
  logic                 final_stop;

  // Parity folded over the incoming word; seeded with 1 for odd parity.
  assign par_chain[0] = PAR_ODD;
  generate
    for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_parity
      assign par_chain[gi+1] = par_chain[gi] ^ data_in[gi];
    end
  endgenerate
  assign par_calc   = par_chain[DATA_BITS];
  assign final_stop = (stop_cnt_reg == STOP_LAST);

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:   if (send) state_next = PEND;
      PEND:   if (baud_tick) state_next = START;
      START:  if (baud_tick) state_next = DATA;
      DATA: begin
        if (baud_tick && (bit_cnt_reg >= LAST_BIT)) begin
          state_next = PAR_ON ? PARITY : STOP;
        end
      end
      PARITY: if (baud_tick) state_next = STOP;
      STOP:   if (baud_tick && final_stop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / datapath next-value logic
  always_comb begin
    shift_next    = shift_reg;
    bit_cnt_next  = bit_cnt_reg;
    stop_cnt_next = stop_cnt_reg;
    parity_next   = parity_reg;
    data_tx_next  = data_tx_reg;
    active_next   = active_reg;
    done_next     = 1'b0;
    unique case (state_reg)
      IDLE: begin
        data_tx_next = 1'b1;
        if (send) begin
          shift_next    = data_in;
          parity_next   = par_calc;
          bit_cnt_next  = '0;
          stop_cnt_next = 1'b0;
          active_next   = 1'b1;
        end
      end
      PEND: begin
        if (baud_tick) data_tx_next = 1'b0;
      end
      START: begin
        if (baud_tick) begin
          data_tx_next = shift_reg[0];
          bit_cnt_next = '0;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_cnt_reg < LAST_BIT) begin
            // Bit 1 of the current word becomes bit 0 after this shift.
            shift_next   = {1'b0, shift_reg[DATA_BITS-1:1]};
            data_tx_next = shift_reg[1];
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end else if (PAR_ON) begin
            data_tx_next = parity_reg;
          end else begin
            data_tx_next  = 1'b1;
            stop_cnt_next = 1'b0;
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          data_tx_next  = 1'b1;
          stop_cnt_next = 1'b0;
        end
      end
      STOP: begin
        if (baud_tick) begin
          data_tx_next = 1'b1;
          if (!final_stop) begin
            stop_cnt_next = 1'b1;
          end else begin
            done_next   = 1'b1;
            active_next = 1'b0;
          end
        end
      end
      default: begin
        data_tx_next = 1'b1;
        active_next  = 1'b0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      parity_reg   <= 1'b0;
      data_tx_reg  <= 1'b1;
      active_reg   <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      shift_reg    <= shift_next;
      bit_cnt_reg  <= bit_cnt_next;
      stop_cnt_reg <= stop_cnt_next;
      parity_reg   <= parity_next;
      data_tx_reg  <= data_tx_next;
      active_reg   <= active_next;
      done_reg     <= done_next;
    end
  end

  assign data_tx     = data_tx_reg;
  assign active_flag = active_reg;
  assign done_flag   = done_reg;

endmodule

// File: tb/tb_uart_tx_piso.sv
// Scoreboard bench for uart_tx_piso: three instances (default, odd parity, no parity + two stop bits).
// Expected line sequences are queued at stimulus time; a negedge monitor captures and compares frames.
module tb_uart_tx_piso;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       baud_tick;
  logic [2:0] send_v;
  logic [7:0] data_v [3];
  logic [2:0] tx, act, dn;

  int n_cmp = 0;
  int n_err = 0;

  // Captured string = line value after each baud_tick while active, ending with the idle '1'.
  string exp_q [3][$];
  string cap [3];

  always #5 clock = ~clock;

  uart_tx_piso u_def (
    .clock(clock), .reset_n(reset_n), .baud_tick(baud_tick), .send(send_v[0]),
    .data_in(data_v[0]), .data_tx(tx[0]), .active_flag(act[0]), .done_flag(dn[0])
  );

  uart_tx_piso #(.PARITY_TYP(1)) u_odd (
    .clock(clock), .reset_n(reset_n), .baud_tick(baud_tick), .send(send_v[1]),
    .data_in(data_v[1]), .data_tx(tx[1]), .active_flag(act[1]), .done_flag(dn[1])
  );

  uart_tx_piso #(.PARITY_EN(0), .STOP_BITS(2)) u_np2 (
    .clock(clock), .reset_n(reset_n), .baud_tick(baud_tick), .send(send_v[2]),
    .data_in(data_v[2]), .data_tx(tx[2]), .active_flag(act[2]), .done_flag(dn[2])
  );

  task automatic check_bit(input string name, input int k, input logic got, input logic want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s dut%0d: got %b expected %b at %0t", name, k, got, want, $time);
    end
  endtask

  // Baud strobe: one clock high every four clocks.
  initial begin
    int div;
    div = 0;
    baud_tick = 1'b0;
    forever begin
      @(posedge clock);
      #1 baud_tick = (div == 3);
      div = (div + 1) % 4;
    end
  end

  // Monitor
  initial begin
    logic       prev_tick, prev_rst_n;
    logic [2:0] prev_act, prev_tx, prev_dn;
    string      e;
    prev_tick  = 1'b0;
    prev_rst_n = 1'b0;
    prev_act   = '0;
    prev_tx    = '1;
    prev_dn    = '0;
    for (int k = 0; k < 3; k++) cap[k] = "";
    forever begin
      @(negedge clock);
      for (int k = 0; k < 3; k++) begin
        if (!prev_rst_n) begin
          cap[k] = "";
        end else begin
          if (!prev_tick) check_bit("line_hold", k, tx[k], prev_tx[k]);
          if (prev_tick && prev_act[k]) cap[k] = $sformatf("%s%0d", cap[k], tx[k]);
          if (prev_act[k] && !act[k]) check_bit("active_until_done", k, dn[k], 1'b1);
          if (dn[k]) begin
            check_bit("done_one_clock", k, prev_dn[k], 1'b0);
            check_bit("active_low_at_done", k, act[k], 1'b0);
            n_cmp++;
            if (exp_q[k].size() == 0) begin
              n_err++;
              $display("FAIL unexpected_frame dut%0d: got %s expected no frame at %0t", k, cap[k], $time);
            end else begin
              e = exp_q[k].pop_front();
              if (cap[k] != e) begin
                n_err++;
                $display("FAIL frame dut%0d: got %s expected %s at %0t", k, cap[k], e, $time);
              end else begin
                $display("frame dut%0d ok: %s", k, cap[k]);
              end
            end
            cap[k] = "";
          end
        end
      end
      prev_tick  = baud_tick;
      prev_rst_n = reset_n;
      prev_act   = act;
      prev_tx    = tx;
      prev_dn    = dn;
    end
  end

  // All pulse/wait tasks start and end just after a rising edge.
  task automatic pulse_all(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    send_v = 3'b111;
    data_v[0] = d0; data_v[1] = d1; data_v[2] = d2;
    @(posedge clock);
    #1 send_v = 3'b000;
    data_v[0] = ~d0; data_v[1] = ~d1; data_v[2] = ~d2;
  endtask

  task automatic wait_quiet(input int budget);
    int n;
    n = 0;
    repeat (2) @(posedge clock);
    do begin
      @(negedge clock);
      n++;
    end while (act != 3'b000 && n < budget);
    if (act != 3'b000) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout_idle: active %b expected 000 after %0d cycles", act, n);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_state();
    for (int k = 0; k < 3; k++) begin
      check_bit("reset_data_tx", k, tx[k], 1'b1);
      check_bit("reset_active", k, act[k], 1'b0);
      check_bit("reset_done", k, dn[k], 1'b0);
    end
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    send_v  = 3'b000;
    for (int k = 0; k < 3; k++) data_v[k] = 8'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_state();
    @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;

    // Basic frames on all three variants
    exp_q[0].push_back("010100101011");
    exp_q[1].push_back("010100101111");
    exp_q[2].push_back("010000000111");
    pulse_all(8'hA5, 8'hA5, 8'h01);
    wait_quiet(400);

    // Mid-frame requests are ignored
    exp_q[0].push_back("010100101011");
    exp_q[1].push_back("000000000111");
    exp_q[2].push_back("011111111111");
    pulse_all(8'hA5, 8'h00, 8'hFF);
    repeat (20) @(posedge clock);
    #1 pulse_all(8'hFF, 8'hFF, 8'h00);
    wait_quiet(400);
    repeat (60) @(posedge clock);
    @(negedge clock);
    for (int k = 0; k < 3; k++) check_bit("no_second_frame", k, act[k], 1'b0);
    @(posedge clock);
    #1;

    // Back-to-back: second request in the done_flag cycle
    exp_q[0].push_back("000111100011");
    exp_q[0].push_back("011000011011");
    send_v[0] = 1'b1; data_v[0] = 8'h3C;
    @(posedge clock);
    #1 send_v[0] = 1'b0; data_v[0] = 8'h00;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!dn[0] && n < 300);
    check_bit("b2b_first_done", 0, dn[0], 1'b1);
    send_v[0] = 1'b1; data_v[0] = 8'hC3;
    @(posedge clock);
    #1 send_v[0] = 1'b0; data_v[0] = 8'h00;
    wait_quiet(400);

    // Reset during DATA aborts the frame, then a clean frame follows
    pulse_all(8'h5A, 8'h5A, 8'h5A);
    repeat (20) @(posedge clock);
    @(negedge clock);
    for (int k = 0; k < 3; k++) check_bit("active_mid_frame", k, act[k], 1'b1);
    @(posedge clock);
    #1 reset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check_reset_state();
    @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    exp_q[0].push_back("001011010011");
    exp_q[1].push_back("001011010111");
    exp_q[2].push_back("001011010111");
    pulse_all(8'h5A, 8'h5A, 8'h5A);
    wait_quiet(400);
    repeat (20) @(posedge clock);

    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (exp_q[k].size() != 0) begin
        n_err++;
        $display("FAIL frames_outstanding dut%0d: got %0d expected 0", k, exp_q[k].size());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
